// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem req/ready handshake, stall hold buffer, IF/ID register.
// Define FETCH_PERF_CNT_EN to build the delivered-instruction counter on fetch_count.
module mips_fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] fetch_count
);

    typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        deliver;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign pc_inc   = pc_q + 32'd4;
    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? {branch_target[31:2], 2'b00}
                                   : {pc4_q[31:28], jump_index, 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        deliver     = 1'b0;
        if (redirect) begin
            // Flush keeps pc4 so a following J still sees its own upper PC bits.
            pc_d    = target;
            state_d = S_REQ;
            valid_d = 1'b0;
            instr_d = 32'h0;
        end else if (state_q == S_REQ) begin
            if (imem_ready) begin
                pc_d = pc_inc;
                if (stall) begin
                    buf_instr_d = imem_rdata;
                    buf_pc4_d   = pc_inc;
                    state_d     = S_HOLD;
                end else begin
                    instr_d = imem_rdata;
                    pc4_d   = pc_inc;
                    valid_d = 1'b1;
                    deliver = 1'b1;
                end
            end else if (!stall) begin
                valid_d = 1'b0;
                instr_d = 32'h0;
            end
        end else if (!stall) begin
            instr_d = buf_instr_q;
            pc4_d   = buf_pc4_q;
            valid_d = 1'b1;
            deliver = 1'b1;
            state_d = S_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            pc_q        <= PC_RESET;
            buf_instr_q <= 32'h0;
            buf_pc4_q   <= 32'h0;
            valid_q     <= 1'b0;
            instr_q     <= 32'h0;
            pc4_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (deliver) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 32'h0;
        else       cnt_q <= cnt_d;
    end

    assign fetch_count = cnt_q;
`else
    logic unused_deliver;
    assign unused_deliver = deliver;
    assign fetch_count    = 32'h0;
`endif

    assign imem_req     = (state_q == S_REQ) && !reset;
    assign imem_addr    = pc_q;
    assign valid_out    = valid_q;
    assign instr_out    = instr_q;
    assign op           = instr_q[31:26];
    assign funct        = instr_q[5:0];
    assign pc_plus4_out = pc4_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: vector table plus reset/wrap sequences.
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, imem_ready;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic        imem_req, valid_out;
    logic [31:0] imem_addr, imem_rdata, instr_out, pc_plus4_out, fetch_count;
    logic [5:0]  op, funct;

    logic        reset2, imem_ready2, imem_req2, valid_out2;
    logic [31:0] imem_addr2, imem_rdata2, instr_out2, pc_plus4_out2, fetch_count2;
    logic [5:0]  op2, funct2;

    always #5 clk = ~clk;

    assign imem_rdata  = imem_addr | 32'h0000_1000;
    assign imem_rdata2 = imem_addr2 | 32'h0000_1000;

    mips_fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .valid_out(valid_out), .instr_out(instr_out),
        .op(op), .funct(funct), .pc_plus4_out(pc_plus4_out), .fetch_count(fetch_count)
    );

    mips_fetch_stage #(.PC_RESET(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset2), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(32'h0), .jump(1'b0), .jump_index(26'h0),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .imem_ready(imem_ready2), .valid_out(valid_out2), .instr_out(instr_out2),
        .op(op2), .funct(funct2), .pc_plus4_out(pc_plus4_out2), .fetch_count(fetch_count2)
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] btgt;
        logic        jmp;
        logic [25:0] jidx;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
    } vec_t;

    vec_t vecs[18];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                                input logic j, input logic [25:0] ji, input logic r,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.br = b; v.btgt = bt; v.jmp = j; v.jidx = ji; v.rdy = r;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_instr = ei; v.exp_pc4 = ep;
        return v;
    endfunction

    logic [31:0] exp_cnt_main, exp_cnt_wrap;

    initial begin
`ifdef FETCH_PERF_CNT_EN
        exp_cnt_main = 32'd8;
        exp_cnt_wrap = 32'd2;
`else
        exp_cnt_main = 32'd0;
        exp_cnt_wrap = 32'd0;
`endif
        //          stall br btgt          jmp jidx     rdy req addr          vld instr         pc4
        vecs[0]  = mk(0, 0, 32'h0,        0, 26'h0,  1,  1, 32'h0000_0000, 1, 32'h0000_1000, 32'h0000_0004);
        vecs[1]  = mk(0, 0, 32'h0,        0, 26'h0,  1,  1, 32'h0000_0004, 1, 32'h0000_1004, 32'h0000_0008);
        vecs[2]  = mk(0, 0, 32'h0,        0, 26'h0,  0,  1, 32'h0000_0008, 0, 32'h0000_0000, 32'h0000_0008);
        vecs[3]  = mk(0, 0, 32'h0,        0, 26'h0,  0,  1, 32'h0000_0008, 0, 32'h0000_0000, 32'h0000_0008);
        vecs[4]  = mk(0, 0, 32'h0,        0, 26'h0,  1,  1, 32'h0000_0008, 1, 32'h0000_1008, 32'h0000_000C);
        vecs[5]  = mk(1, 0, 32'h0,        0, 26'h0,  1,  1, 32'h0000_000C, 1, 32'h0000_1008, 32'h0000_000C);
        vecs[6]  = mk(1, 0, 32'h0,        0, 26'h0,  1,  0, 32'h0000_0010, 1, 32'h0000_1008, 32'h0000_000C);
        vecs[7]  = mk(1, 0, 32'h0,        0, 26'h0,  1,  0, 32'h0000_0010, 1, 32'h0000_1008, 32'h0000_000C);
        vecs[8]  = mk(0, 0, 32'h0,        0, 26'h0,  1,  0, 32'h0000_0010, 1, 32'h0000_100C, 32'h0000_0010);
        vecs[9]  = mk(0, 0, 32'h0,        0, 26'h0,  1,  1, 32'h0000_0010, 1, 32'h0000_1010, 32'h0000_0014);
        vecs[10] = mk(1, 0, 32'h0,        0, 26'h0,  1,  1, 32'h0000_0014, 1, 32'h0000_1010, 32'h0000_0014);
        vecs[11] = mk(1, 1, 32'h0000_0103, 0, 26'h0, 1,  0, 32'h0000_0018, 0, 32'h0000_0000, 32'h0000_0014);
        vecs[12] = mk(0, 0, 32'h0,        0, 26'h0,  1,  1, 32'h0000_0100, 1, 32'h0000_1100, 32'h0000_0104);
        vecs[13] = mk(0, 1, 32'hA000_000C, 0, 26'h0, 1,  1, 32'h0000_0104, 0, 32'h0000_0000, 32'h0000_0104);
        vecs[14] = mk(0, 0, 32'h0,        0, 26'h0,  1,  1, 32'hA000_000C, 1, 32'hA000_100C, 32'hA000_0010);
        vecs[15] = mk(0, 1, 32'h0000_0200, 1, 26'h40, 0, 1, 32'hA000_0010, 0, 32'h0000_0000, 32'hA000_0010);
        vecs[16] = mk(0, 0, 32'h0,        1, 26'h40, 0,  1, 32'h0000_0200, 0, 32'h0000_0000, 32'hA000_0010);
        vecs[17] = mk(0, 0, 32'h0,        0, 26'h0,  1,  1, 32'hA000_0100, 1, 32'hA000_1100, 32'hA000_0104);

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_index = 26'h0; imem_ready = 1'b1;
        reset2 = 1'b1; imem_ready2 = 1'b0;
        tick();
        tick();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, valid_out}, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pc4", pc_plus4_out, 32'h0);
        chk("rst_opfunct", {20'h0, op, funct}, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            stall = vecs[i].stall; branch_taken = vecs[i].br; branch_target = vecs[i].btgt;
            jump = vecs[i].jmp; jump_index = vecs[i].jidx; imem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].exp_req});
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            tick();
            chk($sformatf("v%0d_valid", i), {31'h0, valid_out}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("v%0d_instr", i), instr_out, vecs[i].exp_instr);
            chk($sformatf("v%0d_pc4", i), pc_plus4_out, vecs[i].exp_pc4);
            chk($sformatf("v%0d_op", i), {26'h0, op}, {26'h0, vecs[i].exp_instr[31:26]});
            chk($sformatf("v%0d_funct", i), {26'h0, funct}, {26'h0, vecs[i].exp_instr[5:0]});
        end
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        chk("main_count", fetch_count, exp_cnt_main);

        // Reset while a request is outstanding.
        imem_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_req", {31'h0, imem_req}, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_valid", {31'h0, valid_out}, 32'h0);
        chk("midrst_instr", instr_out, 32'h0);
        chk("midrst_pc4", pc_plus4_out, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_count", fetch_count, 32'h0);

        // PC wrap from the top of the address space.
        reset2 = 1'b0; imem_ready2 = 1'b1;
        #1;
        chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
        tick();
        chk("wrap_instr0", instr_out2, 32'hFFFF_FFFC);
        chk("wrap_pc4_0", pc_plus4_out2, 32'h0);
        chk("wrap_addr1", imem_addr2, 32'h0);
        tick();
        chk("wrap_instr1", instr_out2, 32'h0000_1000);
        chk("wrap_valid1", {31'h0, valid_out2}, 32'h1);
        chk("wrap_count", fetch_count2, exp_cnt_wrap);
        reset2 = 1'b1;
        tick();
        reset2 = 1'b0; imem_ready2 = 1'b0;
        chk("wrap_rst_count", fetch_count2, 32'h0);
        chk("wrap_rst_addr", imem_addr2, 32'hFFFF_FFFC);
        chk("wrap_rst_valid", {31'h0, valid_out2}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch stage with IF/ID pipeline register for the MIPS core.
- Holds the PC, issues requests to instruction memory with a req/ready handshake, and buffers an instruction while decode is stalled.
- Applies branch/jump redirects and presents op/funct/instr to the decode stage and control unit.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  decode stage cannot accept; IF/ID register holds.
- branch_taken  in  1  redirect to branch_target (resolved in decode).
- branch_target  in  32  branch destination; bits [1:0] ignored and forced to 0.
- jump  in  1  J instruction currently in IF/ID; redirect to jump target.
- jump_index  in  26  instr[25:0] of that J instruction.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  byte address of fetch (= PC).
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- imem_ready  in  1  memory accepts and returns data this cycle; sampled only when imem_req=1.
- valid_out  out  1  IF/ID holds a real instruction.
- instr_out  out  32  IF/ID instruction word.
- op  out  6  instr_out[31:26], to control unit.
- funct  out  6  instr_out[5:0], to control unit.
- pc_plus4_out  out  32  PC+4 of the IF/ID instruction.
- fetch_count  out  32  instructions delivered to IF/ID (optional feature, else 0).

Behaviour:
- Reset values:
  - pc = PC_RESET; state = S_REQ; imem_req = 0 during the reset cycle.
  - valid_out = 0; instr_out = 0 (NOP); op = 0; funct = 0; pc_plus4_out = 0; buffer empty; fetch_count = 0.
- Outputs op, funct, instr_out and pc_plus4_out are registered.
- S_REQ:
  - Drive imem_req = 1 and imem_addr = pc; imem_addr stays stable until ready.
  - imem_ready=1 and stall=0: load IF/ID with {imem_rdata, pc+4}, valid_out <= 1, pc <= pc+4, stay in S_REQ.
  - imem_ready=1 and stall=1: capture imem_rdata and pc+4 into the hold buffer, pc <= pc+4, go to S_HOLD.
  - imem_ready=0 and stall=0: IF/ID takes a bubble (valid_out <= 0, instr_out <= 0).
  - imem_ready=0 and stall=1: IF/ID holds.
- S_HOLD:
  - imem_req = 0; IF/ID holds while stall=1.
  - When stall=0: transfer buffer to IF/ID, valid_out <= 1, go to S_REQ.
- Latency: zero-wait memory gives 1 instruction per cycle; an instruction appears in IF/ID the cycle after imem_ready.
- Redirect:
  - target = branch_target & ~3 if branch_taken; else {pc_plus4_out[31:28], jump_index, 2'b00} if jump.
  - branch_taken has priority over jump.
  - Redirect overrides stall and any fetch completing in the same cycle: pc <= target, buffer discarded, IF/ID flushed (valid_out <= 0, instr_out <= 0), state <= S_REQ.
  - A memory response coming back in the redirect cycle is dropped.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Reset mid-operation: all state returns to reset values on the next edge, and any outstanding request is abandoned.
- op and funct always equal the instr_out slices; a bubble or flush therefore presents op=0, funct=0, i.e. R-type sll $0 = NOP.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: fetch_count is a 32-bit register, reset to 0, that increments by 1 on every cycle an instruction is written into IF/ID with valid_out <= 1. Loads from S_REQ and S_HOLD both count; flushes and bubbles do not. Wraps from 32'hFFFF_FFFF to 0.
- Undefined: fetch_count is tied to 32'h0 and no counter logic exists.

Test Plan:
- Reset then zero-wait memory (ready=1, rdata=addr|0x1000) -> imem_addr sequence 0,4,8; instr_out 0x1000,0x1004,0x1008 on consecutive cycles; valid_out=1 from cycle 2.
- Memory wait of 2 cycles at addr 0x8 -> imem_addr stays 0x8; two bubbles (valid_out=0, op=0, funct=0); then instr_out = word at 0x8.
- stall=1 for 3 cycles while ready=1 -> IF/ID unchanged; imem_req=0 in S_HOLD; after release the buffered word appears, with no instruction lost or duplicated.
- branch_taken=1, branch_target=0x0000_0103 with stall=1 -> next imem_addr=0x100; valid_out=0 for 1 cycle; buffer discarded.
- jump=1 and branch_taken=1 together with pc_plus4_out=0xA000_0010, jump_index=0x0000040 -> branch wins; then jump alone -> imem_addr=0xA000_0100.
- PC_RESET=32'hFFFF_FFFC -> imem_addr 0xFFFF_FFFC then 0x0; with FETCH_PERF_CNT_EN defined, fetch_count=2 after two deliveries and 0 after reset asserted mid-run.
